// File: rtl/rotary_quadrature_decoder.sv
// Purpose: rotary shaft front end - 2-flop sync, per-channel debounce (only with ROT_DEBOUNCE_EN), Gray decode, wrapping position.
// Latency: pin change before edge e0 -> clean at e0+1+DEBOUNCE_CYCLES (e0+1 without ROT_DEBOUNCE_EN); step/dir/position/err one edge later.
// Backpressure: none; changes faster than the filter accepts are dropped, illegal Gray jumps pulse err.
module rotary_quadrature_decoder #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int POS_W           = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rot_a,
   input  logic             rot_b,
   output logic             a_clean,
   output logic             b_clean,
   output logic             step,
   output logic             dir,
   output logic [POS_W-1:0] position,
   output logic             err
);

   // Decoder state is the clean pair {a,b}; encoding equals the pin pair so casts are free.
   typedef enum logic [1:0] {
      PAIR_00 = 2'b00,
      PAIR_01 = 2'b01,
      PAIR_10 = 2'b10,
      PAIR_11 = 2'b11
   } pair_t;

   localparam logic signed [2:0] ACC_CW_FULL  = 3'sd3;
   localparam logic signed [2:0] ACC_CCW_FULL = -3'sd3;

   // Index of a pair along the clockwise cycle 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] phase_of(input pair_t p);
      case (p)
         PAIR_00: phase_of = 2'd0;
         PAIR_10: phase_of = 2'd1;
         PAIR_11: phase_of = 2'd2;
         default: phase_of = 2'd3;
      endcase
   endfunction

   // Reject a debounce length the counter cannot reach.
   if (DEBOUNCE_CYCLES < 1 ||
       longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cfg
      $error("rotary_quadrature_decoder: DEBOUNCE_CYCLES out of range for CNT_W");
   end

   logic a_meta;
   logic b_meta;
   logic a_s;
   logic b_s;

   // Two-flop synchronisers; the raw pins are asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_meta <= 1'b0;
         b_meta <= 1'b0;
         a_s    <= 1'b0;
         b_s    <= 1'b0;
      end else begin
         a_meta <= rot_a;
         b_meta <= rot_b;
         a_s    <= a_meta;
         b_s    <= b_meta;
      end
   end

`ifdef ROT_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] a_cnt;
   logic [CNT_W-1:0] b_cnt;

   // Channel A filter: accept a_s only after it has disagreed with a_clean for DEBOUNCE_CYCLES cycles in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_cnt   <= '0;
         a_clean <= 1'b0;
      end else if (a_s == a_clean) begin
         a_cnt   <= '0;
      end else if (a_cnt == CNT_LAST) begin
         a_clean <= a_s;
         a_cnt   <= '0;
      end else begin
         a_cnt   <= a_cnt + CNT_W'(1);
      end
   end

   // Channel B filter: same rule, fully independent of channel A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_cnt   <= '0;
         b_clean <= 1'b0;
      end else if (b_s == b_clean) begin
         b_cnt   <= '0;
      end else if (b_cnt == CNT_LAST) begin
         b_clean <= b_s;
         b_cnt   <= '0;
      end else begin
         b_cnt   <= b_cnt + CNT_W'(1);
      end
   end
`else
   // Filter bypassed: the synchronised pins are the clean channels.
   assign a_clean = a_s;
   assign b_clean = b_s;
`endif

   pair_t             state_q;
   pair_t             state_d;
   pair_t             cur_pair;
   logic signed [2:0] acc_q;
   logic signed [2:0] acc_d;
   logic              prime_q;
   logic              prime_d;
   logic              step_d;
   logic              dir_d;
   logic              err_d;
   logic [POS_W-1:0]  pos_d;
   logic [1:0]        move;
   logic              move_cw;
   logic              move_ccw;
   logic              move_bad;

   // A move of +1 phase is clockwise, +3 is counter-clockwise, +2 means both bits flipped at once.
   assign cur_pair = pair_t'({a_clean, b_clean});
   assign move     = phase_of(cur_pair) - phase_of(state_q);
   assign move_cw  = (move == 2'd1);
   assign move_ccw = (move == 2'd3);
   assign move_bad = (move == 2'd2);

   // Decoder register: previous pair, sub-step accumulator, prime flag and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PAIR_00;
         acc_q    <= '0;
         prime_q  <= 1'b1;
         step     <= 1'b0;
         dir      <= 1'b0;
         position <= '0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         prime_q  <= prime_d;
         step     <= step_d;
         dir      <= dir_d;
         position <= pos_d;
         err      <= err_d;
      end
   end

   // Next-state logic: one decode per change of the clean pair; pulses default low, dir/position hold.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      prime_d = prime_q;
      step_d  = 1'b0;
      dir_d   = dir;
      err_d   = 1'b0;
      pos_d   = position;

      if (cur_pair != state_q) begin
         state_d = cur_pair;
         prime_d = 1'b0;
         if (move_bad) begin
            // Right after reset a double jump just means the pins were not at the detent; adopt it quietly.
            if (!prime_q) begin
               err_d = 1'b1;
               acc_d = '0;
            end
         end else if (cur_pair == PAIR_00) begin
            // Back at the detent: only a full four-transition run in one direction counts as a step.
            acc_d = '0;
            if (move_cw && acc_q == ACC_CW_FULL) begin
               step_d = 1'b1;
               dir_d  = 1'b1;
               pos_d  = position + POS_W'(1);
            end else if (move_ccw && acc_q == ACC_CCW_FULL) begin
               step_d = 1'b1;
               dir_d  = 1'b0;
               pos_d  = position - POS_W'(1);
            end
         end else if (move_cw) begin
            acc_d = acc_q + 3'sd1;
         end else begin
            acc_d = acc_q - 3'sd1;
         end
      end
   end

endmodule

// File: tb/tb_rotary_quadrature_decoder.sv
// Bench for rotary_quadrature_decoder: directed scenarios plus a random pin walk against a cycle-level reference model.
// Expected timing follows the build: DEBOUNCE_CYCLES=4 filter when ROT_DEBOUNCE_EN is defined, direct path otherwise.
// Pins are driven 1 time unit after each rising edge; outputs are sampled there too.
module tb_rotary_quadrature_decoder;
   localparam int D       = 4;
   localparam int POS_W   = 3;
   localparam int POS_MOD = 1 << POS_W;
`ifdef ROT_DEBOUNCE_EN
   localparam bit DEB_EN = 1'b1;
`else
   localparam bit DEB_EN = 1'b0;
`endif
   localparam int FILTER_LAT = DEB_EN ? D : 0;

   logic             clk;
   logic             rst_n;
   logic             rot_a;
   logic             rot_b;
   logic             a_clean;
   logic             b_clean;
   logic             step;
   logic             dir;
   logic [POS_W-1:0] position;
   logic             err;

   rotary_quadrature_decoder #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(16),
      .POS_W(POS_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rot_a(rot_a),
      .rot_b(rot_b),
      .a_clean(a_clean),
      .b_clean(b_clean),
      .step(step),
      .dir(dir),
      .position(position),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: pin pipeline, clean channels, and the rotation bookkeeping.
   bit   m_s1a, m_s1b, m_s2a, m_s2b, m_ca, m_cb;
   int   m_run_a, m_run_b;
   int   m_prev, m_acc, m_pos;
   bit   m_prime, m_step, m_dir, m_err;
   int   phase_tab [4] = '{0, 3, 1, 2};                    // index {a,b} -> clockwise phase
   logic [1:0] pair_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01}; // phase -> {a,b}

   int   checks, errors;
   int   n_step, n_err, n_achg;
   logic last_a;

   task automatic model_reset();
      m_s1a = 0; m_s1b = 0; m_s2a = 0; m_s2b = 0; m_ca = 0; m_cb = 0;
      m_run_a = 0; m_run_b = 0;
      m_prev = 0; m_acc = 0; m_pos = 0;
      m_prime = 1; m_step = 0; m_dir = 0; m_err = 0;
   endtask

   task automatic model_edge();
      bit n_ca, n_cb;
      int cur, mv;
      cur = 32'({m_ca, m_cb});
      m_step = 0;
      m_err  = 0;
      if (cur != m_prev) begin
         mv = (phase_tab[cur] - phase_tab[m_prev] + 4) % 4;
         if (mv == 2) begin
            if (!m_prime) begin
               m_err = 1;
               m_acc = 0;
            end
         end else begin
            m_acc = m_acc + ((mv == 1) ? 1 : -1);
            if (cur == 0) begin
               if (m_acc == 4) begin
                  m_step = 1; m_dir = 1; m_pos = (m_pos + 1) % POS_MOD;
               end else if (m_acc == -4) begin
                  m_step = 1; m_dir = 0; m_pos = (m_pos + POS_MOD - 1) % POS_MOD;
               end
               m_acc = 0;
            end
         end
         m_prime = 0;
         m_prev  = cur;
      end
      n_ca = m_ca;
      n_cb = m_cb;
      if (DEB_EN) begin
         if (m_s2a != m_ca) begin
            m_run_a++;
            if (m_run_a == D) begin n_ca = m_s2a; m_run_a = 0; end
         end else m_run_a = 0;
         if (m_s2b != m_cb) begin
            m_run_b++;
            if (m_run_b == D) begin n_cb = m_s2b; m_run_b = 0; end
         end else m_run_b = 0;
      end
      m_s2a = m_s1a; m_s2b = m_s1b;
      m_s1a = rot_a; m_s1b = rot_b;
      if (!DEB_EN) begin
         n_ca = m_s2a;
         n_cb = m_s2b;
      end
      m_ca = n_ca;
      m_cb = n_cb;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string where);
      check({where, ".a_clean"},  32'(a_clean),  32'(m_ca));
      check({where, ".b_clean"},  32'(b_clean),  32'(m_cb));
      check({where, ".step"},     32'(step),     32'(m_step));
      check({where, ".dir"},      32'(dir),      32'(m_dir));
      check({where, ".position"}, 32'(position), m_pos);
      check({where, ".err"},      32'(err),      32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
      check_outputs("cycle");
      if (step === 1'b1) n_step++;
      if (err === 1'b1) n_err++;
      if (a_clean !== last_a) n_achg++;
      last_a = a_clean;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic set_phase(input int p);
      {rot_a, rot_b} = pair_tab[p % 4];
   endtask

   task automatic do_reset(input logic a, input logic b);
      rot_a = a;
      rot_b = b;
      rst_n = 1'b0;
      #1;
      model_reset();
      last_a = 1'b0;
      check_outputs("reset");
      hold(3);
      rst_n = 1'b1;
   endtask

   // One full detent: four phase changes in the chosen direction, each held ph cycles.
   task automatic detent(input bit cw, input int ph);
      for (int i = 1; i <= 4; i++) begin
         set_phase(cw ? i : 4 - i);
         hold(ph);
      end
   endtask

   function automatic int rnd_ph();
      return int'($urandom_range(12, 25));
   endfunction

   initial begin
      int ph, lat, s0, e0, c0, p, r;
      checks = 0; errors = 0;
      n_step = 0; n_err = 0; n_achg = 0;
      last_a = 1'b0;
      rst_n  = 1'b0;
      rot_a  = 1'b0;
      rot_b  = 1'b0;
      model_reset();

      // Reset state with pins idle at the detent.
      do_reset(1'b0, 1'b0);
      check("reset.position", 32'(position), 0);
      check("reset.dir", 32'(dir), 0);
      hold(5);

      // Clean clockwise detent, 20 cycles per phase.
      s0 = n_step; e0 = n_err;
      for (int i = 1; i <= 3; i++) begin
         set_phase(i);
         hold(20);
      end
      set_phase(0);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (lat < 0 && step === 1'b1) lat = i;
      end
      check("cw.step_latency", lat, FILTER_LAT + 3);
      check("cw.steps", n_step - s0, 1);
      check("cw.err", n_err - e0, 0);
      check("cw.dir", 32'(dir), 1);
      check("cw.position", 32'(position), 1);

      // Back to zero, then eight counter-clockwise detents wrapping through 7.
      detent(1'b0, rnd_ph());
      check("ccw.to_zero", 32'(position), 0);
      s0 = n_step;
      for (int k = 1; k <= 8; k++) begin
         detent(1'b0, rnd_ph());
         check("ccw.position", 32'(position), (POS_MOD - k) % POS_MOD);
         check("ccw.dir", 32'(dir), 0);
      end
      check("ccw.steps", n_step - s0, 8);

      // Channel A bounces 3/3 cycles for 30 cycles, then settles high.
      c0 = n_achg; s0 = n_step; e0 = n_err;
      for (int seg = 0; seg < 10; seg++) begin
         rot_a = (seg % 2 == 0);
         hold(3);
      end
      rot_a = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (lat < 0 && a_clean === 1'b1) lat = i;
      end
      check("bounce.a_clean_changes", n_achg - c0, DEB_EN ? 1 : 11);
      check("bounce.settle_latency", lat, FILTER_LAT + 2);
      check("bounce.steps", n_step - s0, 0);
      check("bounce.err", n_err - e0, 0);
      // 10 -> 00 is a partial rotation: no step, no err.
      rot_a = 1'b0;
      hold(rnd_ph());
      check("partial.steps", n_step - s0, 0);
      check("partial.err", n_err - e0, 0);

      // Illegal jump 01 -> 10, then recovery with a full clockwise detent.
      s0 = n_step; e0 = n_err;
      ph = rnd_ph();
      set_phase(3);
      hold(ph);
      rot_a = 1'b1; rot_b = 1'b0;
      hold(ph);
      check("illegal.err", n_err - e0, 1);
      check("illegal.steps", n_step - s0, 0);
      set_phase(0);
      hold(ph);
      detent(1'b1, ph);
      check("illegal.cw_steps", n_step - s0, 1);
      check("illegal.position", 32'(position), 1);
      check("illegal.err_total", n_err - e0, 1);

      // Pins at 11 through reset release: prime adopts 11 silently.
      do_reset(1'b1, 1'b1);
      s0 = n_step; e0 = n_err;
      hold(rnd_ph());
      check("prime.err", n_err - e0, 0);
      check("prime.a_clean", 32'(a_clean), 1);
      check("prime.b_clean", 32'(b_clean), 1);
      set_phase(3);
      hold(ph);
      set_phase(0);
      hold(ph);
      check("prime.no_step", n_step - s0, 0);
      detent(1'b1, ph);
      check("prime.position", 32'(position), 1);
      check("prime.steps", n_step - s0, 1);
      check("prime.err_total", n_err - e0, 0);

      // Reset mid-rotation after 00 -> 10 -> 11: outputs clear at once.
      set_phase(1);
      hold(ph);
      set_phase(2);
      hold(ph);
      rst_n = 1'b0;
      #1;
      model_reset();
      last_a = 1'b0;
      check("async_rst.position", 32'(position), 0);
      check("async_rst.dir", 32'(dir), 0);
      check("async_rst.a_clean", 32'(a_clean), 0);
      check("async_rst.b_clean", 32'(b_clean), 0);
      hold(3);
      rst_n = 1'b1;
      s0 = n_step; e0 = n_err;
      hold(ph);
      set_phase(3);
      hold(ph);
      set_phase(0);
      hold(ph);
      check("midrst.steps", n_step - s0, 0);
      check("midrst.err", n_err - e0, 0);
      check("midrst.position", 32'(position), 0);

      // Random walk of pin moves with random hold times, checked cycle by cycle.
      p = 0;
      for (int n = 0; n < 80; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 5)      p = (p + 1) % 4;
         else if (r < 9) p = (p + 3) % 4;
         else            p = (p + 2) % 4;
         set_phase(p);
         hold(int'($urandom_range(1, 14)));
      end
      set_phase(0);
      hold(25);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
